// File: rtl/menu_scaler_fade.sv
// Full-screen palettised sprite stretcher with a frame-synchronous fade.
// The ROM address is registered 1 cycle after DrawX. Colour is registered 2+ROM_LATENCY cycles after DrawX.
module menu_scaler_fade #(
  parameter int SRC_W       = 256,
  parameter int SRC_H       = 192,
  parameter int SCR_W       = 640,
  parameter int SCR_H       = 480,
  parameter int IDX_BITS    = 4,
  parameter int ROM_LATENCY = 1,
  parameter int FADE_FRAMES = 2
) (
  input  logic                             vga_clk,
  input  logic                             reset_n,
  input  logic [9:0]                       DrawX,
  input  logic [9:0]                       DrawY,
  input  logic                             blank,
  input  logic                             fade_req,
  input  logic                             fade_dir,
  output logic [$clog2(SRC_W*SRC_H)-1:0]   rom_address,
  input  logic [IDX_BITS-1:0]              rom_q,
  output logic [IDX_BITS-1:0]              pal_index,
  input  logic [3:0]                       pal_red,
  input  logic [3:0]                       pal_green,
  input  logic [3:0]                       pal_blue,
  output logic [3:0]                       red,
  output logic [3:0]                       green,
  output logic [3:0]                       blue,
  output logic                             fade_busy,
  output logic                             fade_done
);
  localparam int AW  = $clog2(SRC_W*SRC_H);
  localparam int SXW = $clog2(SRC_W);
  localparam int SYW = $clog2(SRC_H);
  localparam int EXW = $clog2(SCR_W+SRC_W);
  localparam int EYW = $clog2(SCR_H+SRC_H);
  localparam int FCW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [9:0] SCR_W10 = 10'(SCR_W);
  localparam logic [9:0] SCR_H10 = 10'(SCR_H);

  typedef enum logic [1:0] {ST_ON, ST_OFF, ST_FADE_IN, ST_FADE_OUT} state_t;

  logic [SXW-1:0] sx, sx_n;
  logic [SYW-1:0] sy, sy_n;
  logic [EXW-1:0] ex, ex_n, ex_sum;
  logic [EYW-1:0] ey, ey_n, ey_sum;
  logic [ROM_LATENCY:0] blank_pipe;

  state_t         state, st_s, st_n;
  logic [4:0]     level, lvl_s;
  logic [FCW-1:0] fcnt;
  logic           tick, step, done_s;

  assign pal_index = rom_q;

  // Next-pixel source coordinates feed the address register directly, so the
  // address for DrawX is ready one cycle later.
  always_comb begin
    ex_sum = ex + EXW'(SRC_W);
    sx_n   = sx;
    ex_n   = ex;
    if (DrawX == '0) begin
      sx_n = '0;
      ex_n = '0;
    end else if (DrawX < SCR_W10) begin
      if (ex_sum >= EXW'(SCR_W)) begin
        ex_n = ex_sum - EXW'(SCR_W);
        if (sx != SXW'(SRC_W-1)) sx_n = sx + 1'b1;
      end else begin
        ex_n = ex_sum;
      end
    end
  end

  always_comb begin
    ey_sum = ey + EYW'(SRC_H);
    sy_n   = sy;
    ey_n   = ey;
    if (DrawX == '0) begin
      if (DrawY == '0) begin
        sy_n = '0;
        ey_n = '0;
      end else if (DrawY < SCR_H10) begin
        if (ey_sum >= EYW'(SCR_H)) begin
          ey_n = ey_sum - EYW'(SCR_H);
          if (sy != SYW'(SRC_H-1)) sy_n = sy + 1'b1;
        end else begin
          ey_n = ey_sum;
        end
      end
    end
  end

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lv);
    return 4'((9'(c) * 9'(lv)) >> 4);
  endfunction

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx          <= '0;
      sy          <= '0;
      ex          <= '0;
      ey          <= '0;
      rom_address <= '0;
      blank_pipe  <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      sx          <= sx_n;
      sy          <= sy_n;
      ex          <= ex_n;
      ey          <= ey_n;
      rom_address <= AW'(sy_n) * AW'(SRC_W) + AW'(sx_n);
      blank_pipe  <= {blank_pipe[ROM_LATENCY-1:0], blank};
      red         <= blank_pipe[ROM_LATENCY] ? scale(pal_red,   level) : 4'd0;
      green       <= blank_pipe[ROM_LATENCY] ? scale(pal_green, level) : 4'd0;
      blue        <= blank_pipe[ROM_LATENCY] ? scale(pal_blue,  level) : 4'd0;
    end
  end

  // A step resolves first; a coincident request then acts on the post-step state.
  always_comb begin
    tick   = (DrawX == '0) && (DrawY == '0);
    step   = tick && (state == ST_FADE_IN || state == ST_FADE_OUT) &&
             (fcnt == FCW'(FADE_FRAMES-1));
    st_s   = state;
    lvl_s  = level;
    done_s = 1'b0;
    if (step) begin
      if (state == ST_FADE_OUT) begin
        if (level <= 5'd1) begin
          lvl_s = 5'd0; st_s = ST_OFF; done_s = 1'b1;
        end else lvl_s = level - 5'd1;
      end else begin
        if (level >= 5'd15) begin
          lvl_s = 5'd16; st_s = ST_ON; done_s = 1'b1;
        end else lvl_s = level + 5'd1;
      end
    end
    st_n = st_s;
    if (fade_req) begin
      case (st_s)
        ST_ON, ST_FADE_IN:   if (!fade_dir) st_n = ST_FADE_OUT;
        ST_OFF, ST_FADE_OUT: if (fade_dir)  st_n = ST_FADE_IN;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ON;
      level     <= 5'd16;
      fcnt      <= '0;
      fade_busy <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      state     <= st_n;
      level     <= lvl_s;
      fade_done <= done_s;
      fade_busy <= (st_n == ST_FADE_IN) || (st_n == ST_FADE_OUT);
      if (st_s == ST_ON || st_s == ST_OFF || step) fcnt <= '0;
      else if (tick)                                fcnt <= fcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_menu_scaler_fade.sv
// Scoreboard bench: stimulus pushes expected address/colour/status, a monitor pops them when due.
module tb_menu_scaler_fade;
  localparam int SRC_W = 256, SRC_H = 192, SCR_W = 640, SCR_H = 480;
  localparam int IDX_BITS = 4, L = 1, FF = 2;
  localparam int AW = $clog2(SRC_W*SRC_H);

  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] DrawX = 10'd1, DrawY = 10'd480;
  logic blank = 1'b0, fade_req = 1'b0, fade_dir = 1'b0;
  logic [AW-1:0] rom_address;
  logic [IDX_BITS-1:0] rom_q, pal_index;
  logic [3:0] pal_red, pal_green, pal_blue, red, green, blue;
  logic fade_busy, fade_done;
  bit pal_const = 1'b0;
  bit mon_en = 1'b0;

  menu_scaler_fade #(.SRC_W(SRC_W), .SRC_H(SRC_H), .SCR_W(SCR_W), .SCR_H(SCR_H),
    .IDX_BITS(IDX_BITS), .ROM_LATENCY(L), .FADE_FRAMES(FF)) dut (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .fade_req(fade_req), .fade_dir(fade_dir), .rom_address(rom_address), .rom_q(rom_q),
    .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .fade_busy(fade_busy), .fade_done(fade_done));

  always #5 clk = ~clk;

  // ROM content is address[3:0], delivered L cycles after the address
  logic [IDX_BITS-1:0] rpipe [L];
  always @(posedge clk) begin
    rpipe[0] <= rom_address[IDX_BITS-1:0];
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign rom_q = rpipe[L-1];

  always_comb begin
    if (pal_const) begin
      pal_red = 4'hF; pal_green = 4'h8; pal_blue = 4'h4;
    end else begin
      pal_red = pal_index; pal_green = pal_index ^ 4'hA; pal_blue = ~pal_index;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passed = 0;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Reference model: fade expressed as a level walking between 0 and 16
  int m_level = 16, m_dir = 0, m_frames = 0;
  bit m_done = 1'b0;

  task automatic model_tick();
    if (m_dir != 0) begin
      m_frames++;
      if (m_frames == FF) begin
        m_frames = 0;
        m_level += m_dir;
        if (m_level == 0 || m_level == 16) begin m_dir = 0; m_done = 1'b1; end
      end
    end
  endtask

  task automatic model_req(input bit d);
    if (m_dir == 0) begin
      if (m_level == 16 && !d) begin m_dir = -1; m_frames = 0; end
      else if (m_level == 0 && d) begin m_dir = 1; m_frames = 0; end
    end else if (d && m_dir < 0) m_dir = 1;
    else if (!d && m_dir > 0) m_dir = -1;
  endtask

  function automatic int exp_addr(input int x, input int y);
    int xx, yy, sx, sy;
    xx = (x < SCR_W) ? x : SCR_W - 1;
    yy = (y < SCR_H) ? y : SCR_H - 1;
    sx = xx * SRC_W / SCR_W; if (sx > SRC_W - 1) sx = SRC_W - 1;
    sy = yy * SRC_H / SCR_H; if (sy > SRC_H - 1) sy = SRC_H - 1;
    return sy * SRC_W + sx;
  endfunction

  function automatic int exp_rgb(input int idx, input int lvl, input bit pc);
    int r, g, b;
    if (pc) begin r = 15; g = 8; b = 4; end
    else begin r = idx; g = idx ^ 10; b = 15 - idx; end
    return ((r * lvl / 16) << 8) | ((g * lvl / 16) << 4) | (b * lvl / 16);
  endfunction

  typedef struct {int due; int val;} exp_t;
  exp_t aq[$], cq[$], fq[$];

  task automatic px(input int x, input int y, input bit b, input bit req, input bit dir);
    int a;
    @(posedge clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); blank = b; fade_req = req; fade_dir = dir;
    m_done = 1'b0;
    if (x == 0 && y == 0) model_tick();
    if (req) model_req(dir);
    a = exp_addr(x, y);
    aq.push_back('{cyc + 1, a});
    cq.push_back('{cyc + 2 + L, b ? exp_rgb(a % 16, m_level, pal_const) : 0});
    fq.push_back('{cyc + 1, ((m_dir != 0) ? 2 : 0) | (m_done ? 1 : 0)});
  endtask

  // Frames end with a short blanked line so level changes never hit visible pixels in flight.
  task automatic frame(input bit rnd, input int req_row, input bit req_dir);
    for (int y = 0; y < SCR_H; y++) begin
      if (rnd && (y == 0 || y == SCR_H - 1 || $urandom_range(0, 119) == 0)) begin
        for (int x = 0; x < SCR_W + 8; x++)
          px(x, y, (x < SCR_W) && ($urandom_range(0, 7) != 0), (y == req_row) && (x == 0), req_dir);
      end else begin
        px(0, y, 1'b1, y == req_row, req_dir);
      end
    end
    for (int x = 0; x < L + 3; x++) px(x, SCR_H, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    fade_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (aq.size() + cq.size() + fq.size()) != 0; i++) @(posedge clk);
    chk("drain_pending", aq.size() + cq.size() + fq.size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (aq.size() != 0 && aq[0].due <= cyc) begin
          e = aq.pop_front();
          chk(e.due == cyc ? "rom_address" : "rom_address_late", int'(rom_address), e.val);
        end
        while (cq.size() != 0 && cq[0].due <= cyc) begin
          e = cq.pop_front();
          chk(e.due == cyc ? "rgb" : "rgb_late", int'({red, green, blue}), e.val);
        end
        while (fq.size() != 0 && fq[0].due <= cyc) begin
          e = fq.pop_front();
          chk(e.due == cyc ? "busy_done" : "busy_done_late", int'({fade_busy, fade_done}), e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin : stim
    #12;
    chk("reset_rom_address", int'(rom_address), 0);
    chk("reset_rgb", int'({red, green, blue}), 0);
    chk("reset_busy", int'(fade_busy), 0);
    chk("reset_done", int'(fade_done), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Scaling sweep with random blanking and palette colours
    repeat (2) frame(1'b1, -1, 1'b0);

    // Full fade-out with a constant palette, plus an ignored same-direction request
    pal_const = 1'b1;
    frame(1'b0, 100, 1'b0);
    frame(1'b0, 50, 1'b0);
    for (int f = 0; f < 40 && !(m_level == 0 && m_dir == 0); f++) frame(1'b0, -1, 1'b0);
    frame(1'b0, -1, 1'b0);

    // Fade in three steps, reverse on the step tick, back down to black
    frame(1'b0, 200, 1'b1);
    for (int f = 0; f < 20 && !(m_level == 2 && m_frames == FF - 1); f++) frame(1'b0, -1, 1'b0);
    frame(1'b0, 0, 1'b0);
    for (int f = 0; f < 20 && m_dir != 0; f++) frame(1'b0, -1, 1'b0);

    // Reach a fade-out at level 7, then reset mid-fade
    frame(1'b0, 200, 1'b1);
    for (int f = 0; f < 40 && !(m_level == 8 && m_frames == FF - 1); f++) frame(1'b0, -1, 1'b0);
    frame(1'b0, 0, 1'b0);
    for (int f = 0; f < 20 && m_level != 7; f++) frame(1'b0, -1, 1'b0);
    drain();
    mon_en = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midfade_reset_rgb", int'({red, green, blue}), 0);
    chk("midfade_reset_busy", int'(fade_busy), 0);
    chk("midfade_reset_address", int'(rom_address), 0);
    @(posedge clk);
    #1;
    chk("midfade_reset_rgb_held", int'({red, green, blue}), 0);
    #1 rst_n = 1'b1;
    m_level = 16; m_dir = 0; m_frames = 0;
    mon_en = 1'b1;
    frame(1'b0, -1, 1'b0);
    frame(1'b1, -1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/menu_scaler_fade.md
Name: menu_scaler_fade

Overview:
- Parametrised full-screen sprite renderer for menu and title screens.
- Stretches a SRC_W x SRC_H palettised ROM image over the SCR_W x SCR_H visible area using incremental step accumulators instead of multiply/divide address math.
- Pipelines the external ROM and palette lookup, aligned to the blank signal.
- Adds a frame-synchronous fade-in/fade-out brightness controller.
- Sits between the VGA controller and the colour mux, feeding red/green/blue.

Parameters:
- SRC_W, 256, source image width in pixels (SRC_W <= SCR_W).
- SRC_H, 192, source image height in rows (SRC_H <= SCR_H).
- SCR_W, 640, visible screen width.
- SCR_H, 480, visible screen height.
- IDX_BITS, 4, palette index width.
- ROM_LATENCY, 1, ROM read latency in vga_clk cycles (1..3).
- FADE_FRAMES, 2, frames per brightness step.

Ports:
- vga_clk  in  1  pixel clock, all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current pixel column, 0..799, +1 per clock
- DrawY  in  10  current row
- blank  in  1  1 = visible pixel
- fade_req  in  1  one-cycle pulse that starts a fade
- fade_dir  in  1  sampled with fade_req; 1 = fade in, 0 = fade out
- rom_address  out  clog2(SRC_W*SRC_H)  ROM read address
- rom_q  in  IDX_BITS  ROM data, valid ROM_LATENCY cycles after address
- pal_index  out  IDX_BITS  equals rom_q, to the external palette (combinational)
- pal_red/pal_green/pal_blue  in  4 each  palette colour (combinational from pal_index)
- red/green/blue  out  4 each  registered output colour
- fade_busy  out  1  high while fading
- fade_done  out  1  one-cycle pulse when a fade completes

Behaviour:
- Reset values: red/green/blue = 0, rom_address = 0, fade_busy = 0, fade_done = 0, level = 16 (fully on), state = ON, accumulators = 0, blank pipeline = 0.

X accumulator:
- When DrawX == 0: sx = 0, ex = 0.
- On each clock with DrawX < SCR_W: ex += SRC_W; if ex >= SCR_W then ex -= SCR_W and sx++.
- sx saturates at SRC_W-1.

Y accumulator:
- Steps on the same rule, once per line, when DrawX == 0 and DrawY < SCR_H.
- Reset to sy = 0, ey = 0 when DrawX == 0 and DrawY == 0.
- sy saturates at SRC_H-1.

Address and output pipeline:
- rom_address is registered: sy*SRC_W + sx. When SRC_W is a power of two this reduces to a shift/concat.
- Mapped result for defaults: pixel x maps to floor(x*SRC_W/SCR_W), matching the integer-division formula exactly.
- blank is delayed by 1 + ROM_LATENCY stages. The output register captures palette colour scaled by level when the delayed blank = 1, else 0.
- Total latency DrawX -> red/green/blue: 2 + ROM_LATENCY cycles. The VGA controller compensates for this.

Brightness scaling:
- Per channel: out = (pal_c * level) >> 4, with level in 0..16 (5 bits).
- level 16 passes the colour through unchanged; level 0 gives black.

Fade FSM:
- States: ON, OFF, FADE_IN, FADE_OUT.
- Frame tick = the cycle where DrawX == 0 and DrawY == 0.
- A frame counter counts ticks; every FADE_FRAMES ticks a step fires and the counter clears.
- ON + fade_req with fade_dir = 0 -> FADE_OUT. Frame counter clears.
- OFF + fade_req with fade_dir = 1 -> FADE_IN.
- FADE_OUT: level -= 1 per step; reaching 0 -> OFF, fade_done pulses for 1 cycle.
- FADE_IN: level += 1 per step; reaching 16 -> ON, fade_done pulses.
- fade_req while fading reverses direction from the current level; no jump. fade_req in the same direction as the current state or fade is ignored.
- fade_req coinciding with a step: the step applies first, then the direction change.
- fade_busy = 1 in FADE_IN and FADE_OUT.
- Level changes only on frame ticks, so no mid-frame brightness tearing.
- Asynchronous reset mid-fade returns to ON at level 16 immediately. Outputs read 0 until the pipeline refills.

Test Plan:
- Defaults, ROM_LATENCY = 1, ROM returns address[3:0]: DrawY = 0 sweep. DrawX = 0,2,3,5,639 -> rom_address 0,0,1,2,255. DrawY = 479 row: rom_address = 191*256 + sx. red/green/blue appear 3 cycles after DrawX.
- blank = 0 for a pixel with a nonzero palette colour -> red/green/blue = 0 at the delayed slot, while rom_address still advances.
- fade_req, fade_dir = 0, FADE_FRAMES = 2, pal = F,8,4: level 16 -> 0 over 32 frames. After 1 step the output is E,7,3. At the end fade_done is a single-cycle pulse, state OFF, output black.
- From OFF, fade_req with fade_dir = 1, then fade_req with fade_dir = 0 after 3 steps: level goes 0,1,2,3 then back down to 0. fade_done fires once at 0.
- ROM_LATENCY = 3, SRC_W = 160, SRC_H = 120: latency 5 cycles. DrawX = 639 -> sx = 159. Row 479 -> sy = 119. No sx/sy overflow.
- reset_n low for 1 cycle mid FADE_OUT at level 7: level = 16, fade_busy = 0, red/green/blue = 0 during reset, and the pipeline recovers within 2 + ROM_LATENCY cycles.
